// File: rtl/fifo_pkt_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkt_pkg
// Definitions shared by the packet writer and the read-side depacketizer:
//   - pkt_state_e : framing FSM states (CKS only reachable with the
//                   FIFO_PKT_CKSUM_EN build option)
//   - WIDTH_DEF / LEN_W_DEF / CNT_W_DEF : default widths, so both ends agree
//   - hdr_encode  : header word encoding (payload length, zero-extended)
// ----------------------------------------------------------------------------
package fifo_pkt_pkg;

    localparam int WIDTH_DEF = 8;   // FIFO data width
    localparam int LEN_W_DEF = 4;   // payload length field width
    localparam int CNT_W_DEF = 16;  // completed-packet counter width

    // Header words are built at this width and then cut down to the FIFO
    // width, so one function serves every WIDTH >= LEN_W configuration.
    localparam int HDR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        CKS  = 2'd3
    } pkt_state_e;

    // Header word = payload length in the low bits, upper bits zero. The
    // depacketizer reads the length back from the low LEN_W bits.
    function automatic logic [HDR_W-1:0] hdr_encode(input logic [HDR_W-1:0] len);
        return len;
    endfunction

endpackage

// File: rtl/fifo_pkt_writer_if.sv
// ----------------------------------------------------------------------------
// fifo_pkt_writer_if
// Bundles the packet command, payload stream and FIFO write port of the
// packet writer.
//   master modport : the packet writer (drives s_ready, wr, wr_data, status)
//   slave  modport : the surrounding logic (drives command, payload, full)
// Signals:
//   pkt_start, pkt_len   packet command (one-cycle strobe + payload length)
//   s_valid, s_data      payload stream, s_ready back-pressure
//   full                 FIFO full flag (w_clk domain, registered)
//   wr, wr_data          FIFO write port
//   busy, pkt_done, cmd_err, pkt_cnt   status
// ----------------------------------------------------------------------------
interface fifo_pkt_writer_if
    import fifo_pkt_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             pkt_start;
    logic [LEN_W-1:0] pkt_len;
    logic             s_valid;
    logic [WIDTH-1:0] s_data;
    logic             s_ready;
    logic             full;
    logic             wr;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             pkt_done;
    logic             cmd_err;
    logic [CNT_W-1:0] pkt_cnt;

    modport master (
        input  pkt_start, pkt_len, s_valid, s_data, full,
        output s_ready, wr, wr_data, busy, pkt_done, cmd_err, pkt_cnt
    );

    modport slave (
        output pkt_start, pkt_len, s_valid, s_data, full,
        input  s_ready, wr, wr_data, busy, pkt_done, cmd_err, pkt_cnt
    );

endinterface

// File: rtl/fifo_pkt_writer.sv
// ----------------------------------------------------------------------------
// fifo_pkt_writer
// Frames a payload stream into length-prefixed packets on the write port of
// the async FIFO: one header word (payload length), N payload words and,
// with FIFO_PKT_CKSUM_EN defined, one trailer word holding the XOR of the
// payload. Honours the FIFO full flag; never writes while full is high.
//
// Build option:
//   FIFO_PKT_CKSUM_EN  append the XOR checksum trailer (CKS state)
//
// Ports:
//   w_clk   write-domain clock
//   w_rst   asynchronous active-low reset
//   bus     fifo_pkt_writer_if.master (command, payload, FIFO port, status)
//
// Parameters must match those of the connected interface; WIDTH >= LEN_W.
// ----------------------------------------------------------------------------
module fifo_pkt_writer
    import fifo_pkt_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                w_clk,
    input  logic                w_rst,
    fifo_pkt_writer_if.master   bus
);

    pkt_state_e       state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;       // payload words still to write
    logic             busy_q;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q;

`ifdef FIFO_PKT_CKSUM_EN
    logic [WIDTH-1:0] cks_q, cks_d;       // running XOR of written payload
`endif

    // ------------------------------------------------------------------
    // Next state and FIFO / stream handshake. wr, s_ready and wr_data are
    // combinational so a stall costs no extra cycle when full drops.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        rem_d       = rem_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        bus.wr      = 1'b0;
        bus.s_ready = 1'b0;
        bus.wr_data = '0;
`ifdef FIFO_PKT_CKSUM_EN
        cks_d       = cks_q;
`endif

        // A command while a packet is running is rejected; the running
        // packet carries on untouched.
        if (bus.pkt_start && (state_q != IDLE)) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.pkt_start) begin
                    if (bus.pkt_len != '0) begin
                        rem_d   = bus.pkt_len;
                        state_d = HDR;
`ifdef FIFO_PKT_CKSUM_EN
                        cks_d   = '0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            HDR: begin
                // rem still holds the commanded length in this state.
                bus.wr      = !bus.full;
                bus.wr_data = WIDTH'(hdr_encode(HDR_W'(rem_q)));
                if (!bus.full) begin
                    state_d = PAY;
                end
            end

            PAY: begin
                bus.s_ready = !bus.full;
                bus.wr_data = bus.s_data;
                if (bus.s_valid && !bus.full) begin
                    bus.wr = 1'b1;
                    rem_d  = rem_q - 1'b1;
`ifdef FIFO_PKT_CKSUM_EN
                    cks_d  = cks_q ^ bus.s_data;
`endif
                    if (rem_q == LEN_W'(1)) begin
`ifdef FIFO_PKT_CKSUM_EN
                        state_d = CKS;
`else
                        state_d = IDLE;
                        done_d  = 1'b1;
`endif
                    end
                end
            end

`ifdef FIFO_PKT_CKSUM_EN
            CKS: begin
                bus.wr      = !bus.full;
                bus.wr_data = cks_q;
                if (!bus.full) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers. A reset mid-packet simply drops back to IDLE; the
    // partial packet is abandoned and no trailer is written.
    // ------------------------------------------------------------------
    always_ff @(posedge w_clk or negedge w_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!w_rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
            err_q   <= err_d;
            // Counter moves on the same edge that raises pkt_done, so the
            // new count is visible together with the pulse; wraps naturally.
            if (done_d) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

`ifdef FIFO_PKT_CKSUM_EN
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            cks_q <= '0;
        end else begin
            cks_q <= cks_d;
        end
    end
`endif

    assign bus.busy     = busy_q;
    assign bus.pkt_done = done_q;
    assign bus.cmd_err  = err_q;
    assign bus.pkt_cnt  = cnt_q;

endmodule
